// File: rtl/hazard_ctrl.sv
// Pipeline hazard/flush controller: load-use stalls, jump/branch flushes and multi-cycle
// mult/div holds, plus saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter int MD_CYCLES = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      if_id_inst,
  input  logic             id_ex_mem_read,
  input  logic [4:0]       id_ex_rt,
  input  logic             id_jump,
  input  logic             mem_branch_taken,
  input  logic             md_start,
  output logic [1:0]       if_id_op,
  output logic             pc_hold,
  output logic             id_ex_hold,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int MDW = (MD_CYCLES > 2) ? $clog2(MD_CYCLES) : 1;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_FLUSH = 2'b01;
  localparam logic [1:0] OP_HOLD  = 2'b10;

  typedef enum logic {IDLE, MD_BUSY} state_e;

  state_e           state_q, state_d;
  logic [MDW-1:0]   md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic [5:0] opcode;
  logic [4:0] inst_rs;
  logic [4:0] inst_rt;
  logic       rt_is_source;
  logic       load_use;
  logic       unused_inst;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign opcode      = if_id_inst[31:26];
  assign inst_rs     = if_id_inst[25:21];
  assign inst_rt     = if_id_inst[20:16];
  assign unused_inst = ^if_id_inst[15:0];

  // rt is a read operand only for R-type, beq, bne and sw; for other I-types it is the destination.
  assign rt_is_source = (opcode == 6'b000000) || (opcode == 6'b000100) ||
                        (opcode == 6'b000101) || (opcode == 6'b101011);

  assign load_use = id_ex_mem_read && (id_ex_rt != 5'd0) &&
                    ((id_ex_rt == inst_rs) || ((id_ex_rt == inst_rt) && rt_is_source));

  always_comb begin
    if_id_op     = OP_LOAD;
    pc_hold      = 1'b0;
    id_ex_hold   = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    if (!reset) begin
      if (mem_branch_taken) begin
        if_id_op     = OP_FLUSH;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
      end else if (state_q == MD_BUSY) begin
        if_id_op     = OP_HOLD;
        pc_hold      = 1'b1;
        id_ex_hold   = 1'b1;
        ex_mem_flush = 1'b1;
      end else if (load_use) begin
        if_id_op    = OP_HOLD;
        pc_hold     = 1'b1;
        id_ex_flush = 1'b1;
      end else if (id_jump) begin
        if_id_op = OP_FLUSH;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    if (mem_branch_taken) begin
      // A taken branch cancels any wrong-path mult/div, including one starting now.
      state_d  = IDLE;
      md_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (md_start) begin
            state_d  = MD_BUSY;
            md_cnt_d = MDW'(MD_CYCLES - 2);
          end
        end
        MD_BUSY: begin
          if (md_cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            md_cnt_d = md_cnt_q - MDW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign stall_cnt_d = pc_hold                ? sat_inc(stall_cnt_q) : stall_cnt_q;
  assign flush_cnt_d = (if_id_op == OP_FLUSH) ? sat_inc(flush_cnt_q) : flush_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
